apu_master_port: RTL and testbench
==================================

# apu_master_port

Core-side initiator for the shared APU/FPU request/response protocol. Accepts operations from a core, registers them onto the APU request channel with a tagged `apu_ID_o`, and tracks up to `MAX_OUTSTANDING` in-flight operations in a reorder buffer. The FPU may return results out of order; the block always accepts them and delivers them to the core in issue order. It sits between the core's FP decode stage and the FPU interconnect, facing the FPU wrapper's slave port.

## Interface

**Parameters**
- `ID_WIDTH`, default 9: width of APU transaction ID.
- `NB_ARGS`, default 2: number of operands.
- `OPCODE_WIDTH`, default 6: width of APU opcode, `{vec_op, op_mod, op}`.
- `DATA_WIDTH`, default 32: operand and result width.
- `FLAGS_IN_WIDTH`, default 15: request flags, `{int_fmt, src_fmt, dst_fmt, rnd_mode}`.
- `FLAGS_OUT_WIDTH`, default 5: result status flags.
- `MAX_OUTSTANDING`, default 4: reorder-buffer depth; power of two, ≥2.
- `SRC_ID`, default 0: value placed in the upper `ID_WIDTH-TAG_BITS` ID bits.
- Derived: `TAG_BITS = $clog2(MAX_OUTSTANDING)`, with `TAG_BITS < ID_WIDTH`.

**Ports**
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset. Single clock domain; reset is asynchronous and active-low.
- `core_req_i`, in, 1: core request valid.
- `core_gnt_o`, out, 1: request accepted this cycle.
- `core_operands_i`, in, `NB_ARGS*DATA_WIDTH`: operands.
- `core_op_i`, in, `OPCODE_WIDTH`: opcode.
- `core_flags_i`, in, `FLAGS_IN_WIDTH`: request flags.
- `core_rvalid_o`, out, 1: in-order result valid.
- `core_rready_i`, in, 1: core accepts result.
- `core_rdata_o`, out, `DATA_WIDTH`: result data.
- `core_rflags_o`, out, `FLAGS_OUT_WIDTH`: result status.
- `apu_req_o`, out, 1: APU request valid.
- `apu_gnt_i`, in, 1: APU grant.
- `apu_ID_o`, out, `ID_WIDTH`: `{SRC_ID, tag}`.
- `apu_operands_o`, `apu_op_o`, `apu_flags_o`, out: registered request payload.
- `apu_rvalid_i`, in, 1: APU response valid. No backpressure.
- `apu_rdata_i`, `apu_rflags_i`, `apu_rID_i`, in: response payload.
- `apu_rready_o`, out, 1: tied to 1.
- `busy_o`, out, 1: any entry allocated.
- `err_o`, out, 1: sticky unexpected-response flag.

## Operation

**State**
- Request holding register `hold_valid_q` plus payload.
- Write pointer `wr_ptr`, read pointer `rd_ptr`, both `TAG_BITS` wide and wrapping modulo `MAX_OUTSTANDING`.
- Allocation counter `alloc_cnt`, range 0..`MAX_OUTSTANDING`.
- Per-entry `pending` and `done` bits, plus data and flags storage.

**Issue**
- `core_gnt_o = (~hold_valid_q | apu_gnt_i) & (alloc_cnt < MAX_OUTSTANDING)`.
- On `core_req_i & core_gnt_o`:
  - load the hold register with the payload and tag `wr_ptr`;
  - set `pending[wr_ptr]`;
  - increment `wr_ptr` and `alloc_cnt`.
- `apu_req_o = hold_valid_q`.
- While `apu_req_o & ~apu_gnt_i`, the payload and `apu_ID_o` hold stable and `apu_req_o` is never retracted.
- On grant with no new core request, `hold_valid_q` clears.

**Response capture**
- Let `idx = apu_rID_i[TAG_BITS-1:0]`.
- The response is accepted when all of the following hold:
  - `apu_rvalid_i`;
  - the upper ID bits equal `SRC_ID`;
  - `pending[idx]` is set;
  - `done[idx]` is clear.
- An accepted response writes data and flags and sets `done[idx]`.
- Any other `apu_rvalid_i` is dropped and sets `err_o`. `err_o` clears only on reset.

**Delivery**
- `core_rvalid_o = done[rd_ptr]`; data and flags come from entry `rd_ptr`.
- On `core_rvalid_o & core_rready_i`:
  - clear `pending` and `done` of `rd_ptr`;
  - increment `rd_ptr`;
  - decrement `alloc_cnt`.
- Allocation and delivery in the same cycle leave `alloc_cnt` unchanged.
- `busy_o = (alloc_cnt != 0)`.

## Timing

**Reset**
- All outputs 0 except `apu_rready_o` (1) and `core_gnt_o` (1 when `core_req_i`, since credits are available).
- Pointers, counter, `pending`, `done` and `err_o` reset to 0.
- Reset asserted mid-operation discards all in-flight state. Responses arriving after reset for pre-reset IDs flag `err_o`.

**Latency**
- Core handshake in cycle t → `apu_req_o` high in t+1.
- `apu_rvalid_i` in cycle t → `core_rvalid_o` in t+1, provided the entry is at `rd_ptr`.
- A core delivery takes one cycle per entry.

**Boundary cases**
- Full (`alloc_cnt == MAX_OUTSTANDING`): `core_gnt_o` is 0. A delivery in cycle t frees a credit visible in t+1.
- Response write and delivery of a different entry in the same cycle: both take effect.
- Response for the `rd_ptr` entry in the same cycle that entry's `core_rready_i` is sampled: cannot occur, because that entry's `done` is still 0.
- Back-to-back issue: one request per cycle while `apu_gnt_i` is high and credits remain.

## Test plan

- **Single op:** core sends op `0x05`, operands `{0x3F800000, 0x40000000}`; APU grants at once and responds 3 cycles later with ID `{SRC_ID, 0}` and data `0x40400000` → `core_rvalid_o` one cycle later with `0x40400000`; `busy_o` drops after delivery.
- **Out-of-order completion:** issue 4 ops (tags 0–3); responses arrive in order 2, 0, 3, 1 → core receives results in tag order 0, 1, 2, 3; `core_gnt_o` is low while 4 are outstanding.
- **Grant stall:** hold `apu_gnt_i` low for 5 cycles with a request pending → `apu_req_o`, payload and ID stable throughout; a second core request is not granted until the APU grant.
- **Core backpressure:** `core_rready_i` low while all 4 responses arrive → all captured, no `err_o`, then 4 back-to-back deliveries.
- **Bad responses:** response with wrong `SRC_ID`, then with a non-pending tag, then a duplicate for a completed tag → each is dropped; `err_o` sets and stays 1; valid results are unaffected.
- **Reset mid-flight:** assert `rst_n` low with 3 outstanding → all outputs return to reset values, and a new op issues with tag 0.

Source files
------------

// File: rtl/apu_master_port.sv
// apu_master_port: core-side initiator for the shared APU/FPU protocol.
// Registers core operations onto the APU request channel with a tagged ID,
// tracks in-flight operations in a reorder buffer, accepts out-of-order
// responses and hands results back to the core in issue order.
module apu_master_port #(
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 2,
    parameter int OPCODE_WIDTH    = 6,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SRC_ID          = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    // core request side
    input  logic                            core_req_i,
    output logic                            core_gnt_o,
    input  logic [NB_ARGS*DATA_WIDTH-1:0]   core_operands_i,
    input  logic [OPCODE_WIDTH-1:0]         core_op_i,
    input  logic [FLAGS_IN_WIDTH-1:0]       core_flags_i,
    // core result side
    output logic                            core_rvalid_o,
    input  logic                            core_rready_i,
    output logic [DATA_WIDTH-1:0]           core_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]      core_rflags_o,
    // APU request channel
    output logic                            apu_req_o,
    input  logic                            apu_gnt_i,
    output logic [ID_WIDTH-1:0]             apu_ID_o,
    output logic [NB_ARGS*DATA_WIDTH-1:0]   apu_operands_o,
    output logic [OPCODE_WIDTH-1:0]         apu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]       apu_flags_o,
    // APU response channel
    input  logic                            apu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           apu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]      apu_rflags_i,
    input  logic [ID_WIDTH-1:0]             apu_rID_i,
    output logic                            apu_rready_o,
    // status
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int TAG_BITS = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W    = TAG_BITS + 1;
    localparam int UP_W     = ID_WIDTH - TAG_BITS;
    localparam logic [UP_W-1:0]  SRC_UP  = UP_W'(SRC_ID);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    // request holding register
    logic                          hold_valid_q;
    logic [ID_WIDTH-1:0]           hold_id_q;
    logic [NB_ARGS*DATA_WIDTH-1:0] hold_operands_q;
    logic [OPCODE_WIDTH-1:0]       hold_op_q;
    logic [FLAGS_IN_WIDTH-1:0]     hold_flags_q;

    // reorder buffer bookkeeping
    logic [TAG_BITS-1:0]           wr_ptr;
    logic [TAG_BITS-1:0]           rd_ptr;
    logic [CNT_W-1:0]              alloc_cnt;
    logic [MAX_OUTSTANDING-1:0]    pending;
    logic [MAX_OUTSTANDING-1:0]    done;
    logic [MAX_OUTSTANDING-1:0][DATA_WIDTH-1:0]      rob_data;
    logic [MAX_OUTSTANDING-1:0][FLAGS_OUT_WIDTH-1:0] rob_flags;
    logic                          err_q;

    logic                          issue;
    logic                          deliver;
    logic [TAG_BITS-1:0]           rsp_idx;
    logic                          rsp_src_ok;
    logic                          rsp_ok;

    // A new op may enter whenever the holding slot is free or is being
    // granted this cycle, and a reorder-buffer entry is still free.
    assign core_gnt_o = (~hold_valid_q | apu_gnt_i) & (alloc_cnt < CNT_MAX);
    assign issue      = core_req_i & core_gnt_o;
    assign deliver    = core_rvalid_o & core_rready_i;

    // Responses are only trusted for our source, an allocated tag, and
    // a tag that has not already completed.
    assign rsp_idx    = apu_rID_i[TAG_BITS-1:0];
    assign rsp_src_ok = (apu_rID_i[ID_WIDTH-1:TAG_BITS] == SRC_UP);
    assign rsp_ok     = apu_rvalid_i & rsp_src_ok & pending[rsp_idx] & ~done[rsp_idx];

    assign apu_req_o      = hold_valid_q;
    assign apu_ID_o       = hold_id_q;
    assign apu_operands_o = hold_operands_q;
    assign apu_op_o       = hold_op_q;
    assign apu_flags_o    = hold_flags_q;
    assign apu_rready_o   = 1'b1;

    assign core_rvalid_o = done[rd_ptr];
    assign core_rdata_o  = rob_data[rd_ptr];
    assign core_rflags_o = rob_flags[rd_ptr];
    assign busy_o        = (alloc_cnt != '0);
    assign err_o         = err_q;

    // Holding register: loads on core handshake, frees on APU grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q    <= 1'b0;
            hold_id_q       <= '0;
            hold_operands_q <= '0;
            hold_op_q       <= '0;
            hold_flags_q    <= '0;
        end else if (issue) begin
            hold_valid_q    <= 1'b1;
            hold_id_q       <= {SRC_UP, wr_ptr};
            hold_operands_q <= core_operands_i;
            hold_op_q       <= core_op_i;
            hold_flags_q    <= core_flags_i;
        end else if (apu_gnt_i) begin
            hold_valid_q    <= 1'b0;
        end
    end

    // Pointers and the outstanding-entry count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            alloc_cnt <= '0;
        end else begin
            if (issue)   wr_ptr <= wr_ptr + 1'b1;
            if (deliver) rd_ptr <= rd_ptr + 1'b1;
            case ({issue, deliver})
                2'b10:   alloc_cnt <= alloc_cnt + 1'b1;
                2'b01:   alloc_cnt <= alloc_cnt - 1'b1;
                default: alloc_cnt <= alloc_cnt;
            endcase
        end
    end

    // Per-entry state. Allocation and delivery never hit the same entry in
    // one cycle (a free write slot equal to rd_ptr means the buffer is empty).
    for (genvar e = 0; e < MAX_OUTSTANDING; e++) begin : g_entry
        localparam logic [TAG_BITS-1:0] IDX = TAG_BITS'(e);
        logic                       pend_q;
        logic                       done_q;
        logic [DATA_WIDTH-1:0]      data_q;
        logic [FLAGS_OUT_WIDTH-1:0] flags_q;

        // Track allocation, completion and retirement of this entry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_q  <= 1'b0;
                done_q  <= 1'b0;
                data_q  <= '0;
                flags_q <= '0;
            end else begin
                if (deliver && rd_ptr == IDX) begin
                    pend_q <= 1'b0;
                    done_q <= 1'b0;
                end
                if (issue && wr_ptr == IDX) pend_q <= 1'b1;
                if (rsp_ok && rsp_idx == IDX) begin
                    done_q  <= 1'b1;
                    data_q  <= apu_rdata_i;
                    flags_q <= apu_rflags_i;
                end
            end
        end

        assign pending[e]   = pend_q;
        assign done[e]      = done_q;
        assign rob_data[e]  = data_q;
        assign rob_flags[e] = flags_q;
    end

    // Sticky flag for any response that could not be matched to an entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        err_q <= 1'b0;
        else if (apu_rvalid_i && !rsp_ok)  err_q <= 1'b1;
    end

endmodule

// File: tb/tb_apu_master_port.sv
// Self-checking bench for apu_master_port: directed scenarios plus a random
// mix, all checked against a queue-based model of in-order result delivery.
module tb_apu_master_port;

    localparam int IDW  = 9;
    localparam int NA   = 2;
    localparam int OPW  = 6;
    localparam int DW   = 32;
    localparam int FIW  = 15;
    localparam int FOW  = 5;
    localparam int MAXO = 4;
    localparam int SRC  = 5;
    localparam int TB   = 2;
    localparam int UPW  = IDW - TB;

    logic              clk;
    logic              rst_n;
    logic              core_req;
    logic              core_gnt_o;
    logic [NA*DW-1:0]  core_operands;
    logic [OPW-1:0]    core_op;
    logic [FIW-1:0]    core_flags;
    logic              core_rvalid_o;
    logic              core_rready;
    logic [DW-1:0]     core_rdata_o;
    logic [FOW-1:0]    core_rflags_o;
    logic              apu_req_o;
    logic              apu_gnt;
    logic [IDW-1:0]    apu_ID_o;
    logic [NA*DW-1:0]  apu_operands_o;
    logic [OPW-1:0]    apu_op_o;
    logic [FIW-1:0]    apu_flags_o;
    logic              apu_rvalid;
    logic [DW-1:0]     apu_rdata;
    logic [FOW-1:0]    apu_rflags;
    logic [IDW-1:0]    apu_rID;
    logic              apu_rready_o;
    logic              busy_o;
    logic              err_o;

    apu_master_port #(
        .ID_WIDTH(IDW), .NB_ARGS(NA), .OPCODE_WIDTH(OPW), .DATA_WIDTH(DW),
        .FLAGS_IN_WIDTH(FIW), .FLAGS_OUT_WIDTH(FOW), .MAX_OUTSTANDING(MAXO),
        .SRC_ID(SRC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req), .core_gnt_o(core_gnt_o),
        .core_operands_i(core_operands), .core_op_i(core_op), .core_flags_i(core_flags),
        .core_rvalid_o(core_rvalid_o), .core_rready_i(core_rready),
        .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt), .apu_ID_o(apu_ID_o),
        .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
        .apu_rvalid_i(apu_rvalid), .apu_rdata_i(apu_rdata), .apu_rflags_i(apu_rflags),
        .apu_rID_i(apu_rID), .apu_rready_o(apu_rready_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tags outstanding in issue order, and per-tag results.
    int            q[$];
    logic [DW-1:0] m_data[MAXO];
    logic [FOW-1:0] m_flags[MAXO];
    bit            m_done[MAXO];
    bit            m_err;
    int            m_wr;
    int            n_tests;
    int            n_fail;

    function automatic logic [IDW-1:0] mk_id(input int up, input int tag);
        return {UPW'(up), TB'(tag)};
    endfunction

    function automatic bit in_q(input int tag);
        foreach (q[k]) if (q[k] == tag) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        q.delete();
        for (int i = 0; i < MAXO; i++) m_done[i] = 1'b0;
        m_err = 1'b0;
        m_wr  = 0;
    endtask

    // Issue one op with the APU granting immediately.
    task automatic issue_op(input logic [NA*DW-1:0] ops, input logic [OPW-1:0] op,
                            input logic [FIW-1:0] fl);
        logic [IDW-1:0] exp_id;
        core_req = 1'b1; apu_gnt = 1'b1;
        core_operands = ops; core_op = op; core_flags = fl;
        #1;
        n_tests++;
        if (core_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL issue_gnt: got %b want 1", core_gnt_o);
        end
        exp_id = mk_id(SRC, m_wr);
        q.push_back(m_wr);
        m_done[m_wr] = 1'b0;
        m_wr = (m_wr + 1) % MAXO;
        tick;
        core_req = 1'b0; core_operands = {$urandom, $urandom}; core_op = OPW'($urandom);
        #1;
        n_tests++;
        if (apu_req_o !== 1'b1 || apu_ID_o !== exp_id || apu_operands_o !== ops ||
            apu_op_o !== op || apu_flags_o !== fl) begin
            n_fail++;
            $display("FAIL issue_req: req=%b id=%h ops=%h op=%h fl=%h want req=1 id=%h ops=%h op=%h fl=%h",
                     apu_req_o, apu_ID_o, apu_operands_o, apu_op_o, apu_flags_o, exp_id, ops, op, fl);
        end
        tick;
    endtask

    // One-cycle APU response; core_rready is low throughout.
    task automatic respond(input logic [IDW-1:0] id, input logic [DW-1:0] d,
                           input logic [FOW-1:0] f);
        int tag;
        bit acc;
        bit exp_rv;
        apu_rvalid = 1'b1; apu_rID = id; apu_rdata = d; apu_rflags = f;
        tag = int'(id[TB-1:0]);
        acc = (id[IDW-1:TB] == UPW'(SRC)) && in_q(tag) && !m_done[tag];
        if (acc) begin
            m_done[tag] = 1'b1; m_data[tag] = d; m_flags[tag] = f;
        end else begin
            m_err = 1'b1;
        end
        tick;
        apu_rvalid = 1'b0; apu_rdata = $urandom;
        #1;
        n_tests++;
        if (err_o !== m_err) begin
            n_fail++; $display("FAIL rsp_err: id=%h got %b want %b", id, err_o, m_err);
        end
        exp_rv = (q.size() > 0) && m_done[q[0]];
        n_tests++;
        if (core_rvalid_o !== exp_rv) begin
            n_fail++; $display("FAIL rsp_rvalid: id=%h got %b want %b", id, core_rvalid_o, exp_rv);
        end
    endtask

    // One cycle with core_rready high; checks the in-order head result.
    task automatic deliver;
        bit exp_rv;
        core_rready = 1'b1;
        #1;
        exp_rv = (q.size() > 0) && m_done[q[0]];
        n_tests++;
        if (core_rvalid_o !== exp_rv) begin
            n_fail++; $display("FAIL dlv_rvalid: got %b want %b", core_rvalid_o, exp_rv);
        end
        if (exp_rv) begin
            n_tests++;
            if (core_rdata_o !== m_data[q[0]] || core_rflags_o !== m_flags[q[0]]) begin
                n_fail++;
                $display("FAIL dlv_data: tag %0d got %h/%h want %h/%h", q[0],
                         core_rdata_o, core_rflags_o, m_data[q[0]], m_flags[q[0]]);
            end
        end
        tick;
        core_rready = 1'b0;
        if (exp_rv) begin
            m_done[q[0]] = 1'b0;
            void'(q.pop_front());
        end
        n_tests++;
        if (busy_o !== (q.size() != 0)) begin
            n_fail++; $display("FAIL dlv_busy: got %b want %b", busy_o, q.size() != 0);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        n_tests++;
        if (core_gnt_o !== 1'b1 || apu_rready_o !== 1'b1) begin
            n_fail++; $display("FAIL %s_gnt_rready: gnt=%b rready=%b want 1/1", nm, core_gnt_o, apu_rready_o);
        end
        n_tests++;
        if (apu_req_o !== 1'b0 || apu_ID_o !== '0 || apu_operands_o !== '0 ||
            apu_op_o !== '0 || apu_flags_o !== '0) begin
            n_fail++; $display("FAIL %s_apu: req=%b id=%h ops=%h want all 0", nm, apu_req_o, apu_ID_o, apu_operands_o);
        end
        n_tests++;
        if (core_rvalid_o !== 1'b0 || core_rdata_o !== '0 || core_rflags_o !== '0 ||
            busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_core: rvalid=%b rdata=%h rflags=%h busy=%b err=%b want all 0",
                     nm, core_rvalid_o, core_rdata_o, core_rflags_o, busy_o, err_o);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; core_req = 1'b1; apu_gnt = 1'b0; core_rready = 1'b0;
        core_operands = '0; core_op = '0; core_flags = '0;
        apu_rvalid = 1'b0; apu_rdata = '0; apu_rflags = '0; apu_rID = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        core_req = 1'b0;
        rst_n = 1'b1;
        model_reset();
        tick;
    endtask

    task automatic test_single_op;
        issue_op({32'h40000000, 32'h3F800000}, 6'h05, 15'h0);
        tick; tick;
        respond(mk_id(SRC, q[0]), 32'h40400000, 5'h0);
        n_tests++;
        if (core_rdata_o !== 32'h40400000) begin
            n_fail++; $display("FAIL single_data: got %h want 40400000", core_rdata_o);
        end
        deliver();
    endtask

    task automatic test_out_of_order;
        int ord[4] = '{2, 0, 3, 1};
        for (int i = 0; i < 4; i++) issue_op({$urandom, $urandom}, OPW'($urandom), FIW'($urandom));
        core_req = 1'b1;
        #1;
        n_tests++;
        if (core_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL full_gnt: got %b want 0", core_gnt_o);
        end
        core_req = 1'b0;
        for (int i = 0; i < 4; i++) respond(mk_id(SRC, q[ord[i]]), $urandom, FOW'($urandom));
        deliver();
        // one retired entry frees a credit on the following cycle
        n_tests++;
        if (core_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL credit_back: got %b want 1", core_gnt_o);
        end
        for (int i = 0; i < 3; i++) deliver();
    endtask

    task automatic test_grant_stall;
        logic [NA*DW-1:0] ops1, ops2;
        logic [IDW-1:0]   id1, id2;
        ops1 = {$urandom, $urandom}; ops2 = {$urandom, $urandom};
        core_req = 1'b1; apu_gnt = 1'b0; core_operands = ops1; core_op = 6'h11; core_flags = 15'h1234;
        #1;
        n_tests++;
        if (core_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_first_gnt: got %b want 1", core_gnt_o);
        end
        id1 = mk_id(SRC, m_wr); q.push_back(m_wr); m_done[m_wr] = 1'b0; m_wr = (m_wr + 1) % MAXO;
        tick;
        core_operands = ops2; core_op = 6'h22; core_flags = 15'h0567;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (apu_req_o !== 1'b1 || apu_ID_o !== id1 || apu_operands_o !== ops1 ||
                apu_op_o !== 6'h11 || apu_flags_o !== 15'h1234 || core_gnt_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: req=%b id=%h ops=%h gnt=%b want 1/%h/%h/0",
                         i, apu_req_o, apu_ID_o, apu_operands_o, core_gnt_o, id1, ops1);
            end
            tick;
        end
        apu_gnt = 1'b1;
        #1;
        n_tests++;
        if (core_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_second_gnt: got %b want 1", core_gnt_o);
        end
        id2 = mk_id(SRC, m_wr); q.push_back(m_wr); m_done[m_wr] = 1'b0; m_wr = (m_wr + 1) % MAXO;
        tick;
        core_req = 1'b0;
        #1;
        n_tests++;
        if (apu_req_o !== 1'b1 || apu_ID_o !== id2 || apu_operands_o !== ops2 || apu_op_o !== 6'h22) begin
            n_fail++; $display("FAIL stall_second_req: req=%b id=%h ops=%h want 1/%h/%h",
                               apu_req_o, apu_ID_o, apu_operands_o, id2, ops2);
        end
        tick;
        n_tests++;
        if (apu_req_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: req=%b want 0", apu_req_o);
        end
        respond(mk_id(SRC, q[1]), $urandom, FOW'($urandom));
        respond(mk_id(SRC, q[0]), $urandom, FOW'($urandom));
        deliver(); deliver();
    endtask

    task automatic test_backpressure;
        int perm[4] = '{0, 1, 2, 3};
        for (int i = 3; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 4; i++) issue_op({$urandom, $urandom}, OPW'($urandom), FIW'($urandom));
        for (int i = 0; i < 4; i++) respond(mk_id(SRC, q[perm[i]]), $urandom, FOW'($urandom));
        for (int i = 0; i < 4; i++) deliver();
    endtask

    task automatic test_random;
        for (int it = 0; it < 300; it++) begin
            int r = $urandom_range(0, 2);
            int cand[$];
            foreach (q[k]) if (!m_done[q[k]]) cand.push_back(q[k]);
            if (r == 0 && q.size() < MAXO)
                issue_op({$urandom, $urandom}, OPW'($urandom), FIW'($urandom));
            else if (r == 1 && cand.size() > 0)
                respond(mk_id(SRC, cand[$urandom_range(0, cand.size() - 1)]), $urandom, FOW'($urandom));
            else
                deliver();
        end
        for (int g = 0; g < 2 * MAXO && q.size() > 0; g++) begin
            if (!m_done[q[0]]) respond(mk_id(SRC, q[0]), $urandom, FOW'($urandom));
            deliver();
        end
    endtask

    task automatic test_bad_responses;
        int a, b;
        logic [DW-1:0] da;
        issue_op({$urandom, $urandom}, OPW'($urandom), FIW'($urandom));
        issue_op({$urandom, $urandom}, OPW'($urandom), FIW'($urandom));
        a = q[0]; b = q[1];
        da = $urandom;
        respond(mk_id(SRC, a), da, 5'h3);
        respond(mk_id(SRC + 1, b), $urandom, FOW'($urandom));   // foreign source
        respond(mk_id(SRC, (b + 1) % MAXO), $urandom, FOW'($urandom)); // never issued
        respond(mk_id(SRC, a), ~da, 5'h1c);                     // duplicate
        respond(mk_id(SRC, b), $urandom, FOW'($urandom));
        deliver(); deliver();
        n_tests++;
        if (err_o !== 1'b1) begin
            n_fail++; $display("FAIL bad_err_sticky: got %b want 1", err_o);
        end
    endtask

    task automatic test_reset_mid_flight;
        for (int i = 0; i < 3; i++) issue_op({$urandom, $urandom}, OPW'($urandom), FIW'($urandom));
        respond(mk_id(SRC, q[1]), $urandom, FOW'($urandom));
        rst_n = 1'b0; core_req = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick;
        rst_n = 1'b1; core_req = 1'b0;
        model_reset();
        tick;
        issue_op({$urandom, $urandom}, OPW'($urandom), FIW'($urandom));  // expects tag 0
        respond(mk_id(SRC, 2), $urandom, FOW'($urandom));               // stale pre-reset tag
        respond(mk_id(SRC, 0), $urandom, FOW'($urandom));
        deliver();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        test_reset();
        test_single_op();
        test_out_of_order();
        test_grant_stall();
        test_backpressure();
        test_random();
        test_bad_responses();
        test_reset_mid_flight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
